player_action_ctrl: RTL and testbench
=====================================

# player_action_ctrl

Sequencer between the PS/2 key-state decoder and the game core. It turns level-held W/S/A/D/space states into discrete, rate-limited game actions:
- direction moves with a first-step-then-auto-repeat cadence and newest-key-wins arbitration;
- shots with a cooldown, a finite magazine and a timed reload.

It runs on the 100 Hz game tick, so one cycle is 10 ms.

## Interface
Parameters:
- INIT_DLY, 30: cycles from a move's first step to its first auto-repeat step (300 ms).
- REPEAT, 10: cycles between auto-repeat steps while the key stays held.
- COOLDOWN, 20: minimum cycles between consecutive `fire` pulses.
- MAX_AMMO, 6: magazine size, ≥1.
- RELOAD_TICKS, 150: reload duration in cycles.

Ports:
- clk_100Hz  in  1  game tick clock. One clock domain; all logic rises on this edge.
- rst_p  in  1  reset. Synchronous, active-low.
- enable  in  1  game running; when low, no actions are issued.
- move_opr  in  4  held key states {W,S,A,D}, bit3=W … bit0=D.
- shoot_sign  in  1  space held.
- move_valid  out  1  one-cycle move step strobe.
- move_dir  out  2  direction of current/last step: 00 up, 01 down, 10 left, 11 right.
- fire  out  1  one-cycle shot strobe.
- ammo  out  $clog2(MAX_AMMO+1)  rounds remaining.
- reloading  out  1  high while a reload is in progress.

## Operation
Both inputs are registered once (`prev_opr`, `prev_shoot`) for edge detection. A newly pressed bit is `new = move_opr & ~prev_opr`.

Move FSM, states IDLE, HOLD:
- IDLE, `new != 0`, enable=1:
  - Select the newest key. If several are new in the same cycle, priority is W>S>A>D.
  - Pulse `move_valid` with that direction, load the counter with INIT_DLY-1, go to HOLD.
- HOLD, selected key still held:
  - Counter decrements each cycle. At 0, pulse `move_valid` and reload the counter with REPEAT-1.
- HOLD, any `new != 0`: preempts. Treat it exactly like a fresh press from IDLE (immediate step, INIT_DLY reload).
- HOLD, selected key released:
  - If other keys are held, switch to the highest-priority held key with the counter at REPEAT-1; there is no immediate step.
  - Otherwise go to IDLE.
- Opposing keys (W+S, A+D) are not cancelled; the newest wins.

Fire FSM, states READY, COOL, RELOAD:
- READY, shoot_sign=1, ammo>0, enable=1:
  - Pulse `fire` and decrement ammo.
  - If ammo becomes 0, go to RELOAD with the counter at RELOAD_TICKS-1. Otherwise go to COOL with the counter at COOLDOWN-2.
- COOL: counter expires, then go to READY. Holding space auto-fires every COOLDOWN cycles.
- RELOAD:
  - `reloading`=1.
  - On counter expiry, set ammo=MAX_AMMO, reloading=0, go to READY.

enable=0:
- Move FSM goes to IDLE; no `move_valid`.
- `fire` is suppressed.
- COOL and RELOAD counters freeze; ammo is held.
- The edge registers keep tracking the inputs. A key already held when enable rises does not step until it is re-pressed.

## Timing
- Reset (rst_p=0 at an edge) gives:
  - move_valid=0, move_dir=00, fire=0, ammo=MAX_AMMO, reloading=0;
  - FSMs in IDLE/READY; prev registers 0; counters 0.
- Reset applied mid-reload or mid-hold aborts it immediately.
- All outputs are registered. An input change sampled at edge k is reflected at edge k+1.
- Moves: press sampled at edge k gives `move_valid` high in cycle k+1. Holding gives steps at k+1+INIT_DLY, then every REPEAT cycles.
- Fire:
  - `fire` at cycle N; space held gives the next `fire` at N+COOLDOWN.
  - If N was the last round: reloading=1 for cycles N+1…N+RELOAD_TICKS; ammo=MAX_AMMO from N+RELOAD_TICKS+1. If space is held, the next fire is at N+RELOAD_TICKS+1.
- Simultaneous move step and fire are independent and may coincide.
- Counters saturate at 0 and never wrap. Each counter's width is sized to its largest parameter.

## Structure
- Shared `game_pkg` (header) holds:
  - the direction encodings DIR_UP/DOWN/LEFT/RIGHT;
  - the key bit indices of move_opr;
  - the FSM state constants for both FSMs.
- One natural sub-module, `tick_down_counter`:
  - parameterised width;
  - load, enable/freeze, zero flag;
  - instantiated once in the move FSM and once in the fire FSM.
- The priority select (W>S>A>D) is a small combinational function inside the top.

## Test plan
- Reset then tap A for 1 cycle: one `move_valid` with move_dir=10, one cycle after the press; nothing further.
- Hold W for 60 cycles from cycle 0: steps at cycles 1, 31, 41, 51; dir=00 throughout.
- Hold W, press D at cycle 15, release D at cycle 25 with W still held:
  - step dir=11 at 16;
  - no step at 25–26;
  - step dir=00 at 36.
- Press S and D in the same cycle: first step has dir=01.
- Hold space 200 cycles, default parameters:
  - fires at 1, 21, 41, 61, 81, 101; ammo falls 5…0;
  - reloading high 102–251; ammo=6 and fire at 252.
- Mid-reload, drop enable for 10 cycles, then pulse rst_p low at cycle 300: the reload completion is delayed by 10 cycles; after reset, ammo=6, reloading=0, no strobes.

Source files
------------

// File: rtl/game_pkg.sv
// Shared encodings for the player action sequencer: step directions,
// key bit positions within move_opr, and the two FSM state sets.
package game_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    // Bit positions of the held-key vector {W,S,A,D}
    localparam int unsigned KEY_W = 3;
    localparam int unsigned KEY_S = 2;
    localparam int unsigned KEY_A = 1;
    localparam int unsigned KEY_D = 0;

    typedef enum logic {
        MV_IDLE = 1'b0,
        MV_HOLD = 1'b1
    } move_state_e;

    typedef enum logic [1:0] {
        FR_READY  = 2'd0,
        FR_COOL   = 2'd1,
        FR_RELOAD = 2'd2
    } fire_state_e;

    // Key bit that produces a given direction
    function automatic logic [1:0] dir_key(input dir_e d);
        case (d)
            DIR_UP:   return 2'(KEY_W);
            DIR_DOWN: return 2'(KEY_S);
            DIR_LEFT: return 2'(KEY_A);
            default:  return 2'(KEY_D);
        endcase
    endfunction

endpackage

// File: rtl/tick_down_counter.sv
// Loadable down counter that saturates at zero and can be frozen.
module tick_down_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;

    // Load has priority; otherwise count down while enabled, stopping at 0
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/player_action_ctrl.sv
// Turns held W/S/A/D/space levels into rate-limited move steps and shots.
// Move: first step, INIT_DLY pause, then REPEAT cadence; newest key wins.
// Fire: COOLDOWN spacing (COOLDOWN >= 2), MAX_AMMO magazine, timed reload.
module player_action_ctrl
    import game_pkg::*;
#(
    parameter int unsigned INIT_DLY     = 30,
    parameter int unsigned REPEAT       = 10,
    parameter int unsigned COOLDOWN     = 20,
    parameter int unsigned MAX_AMMO     = 6,
    parameter int unsigned RELOAD_TICKS = 150
) (
    input  logic                            clk_100Hz,
    input  logic                            rst_p,
    input  logic                            enable,
    input  logic [3:0]                      move_opr,
    input  logic                            shoot_sign,
    output logic                            move_valid,
    output logic [1:0]                      move_dir,
    output logic                            fire,
    output logic [$clog2(MAX_AMMO+1)-1:0]   ammo,
    output logic                            reloading
);

    localparam int unsigned AMMO_W = $clog2(MAX_AMMO + 1);
    localparam int unsigned MV_MAX = (INIT_DLY > REPEAT) ? INIT_DLY : REPEAT;
    localparam int unsigned MV_W   = $clog2(MV_MAX + 1);
    localparam int unsigned FR_MAX = (COOLDOWN > RELOAD_TICKS) ? COOLDOWN : RELOAD_TICKS;
    localparam int unsigned FR_W   = $clog2(FR_MAX + 1);

    localparam logic [MV_W-1:0]   MV_INIT_LD   = MV_W'(INIT_DLY - 1);
    localparam logic [MV_W-1:0]   MV_REP_LD    = MV_W'(REPEAT - 1);
    localparam logic [FR_W-1:0]   FR_COOL_LD   = FR_W'(COOLDOWN - 2);
    localparam logic [FR_W-1:0]   FR_RELOAD_LD = FR_W'(RELOAD_TICKS - 1);
    localparam logic [AMMO_W-1:0] AMMO_FULL    = AMMO_W'(MAX_AMMO);

    // Highest-priority key of a set: W > S > A > D
    function automatic dir_e prio_dir(input logic [3:0] keys);
        if (keys[KEY_W])      return DIR_UP;
        else if (keys[KEY_S]) return DIR_DOWN;
        else if (keys[KEY_A]) return DIR_LEFT;
        else                  return DIR_RIGHT;
    endfunction

    // ---------------- move sequencer ----------------
    logic [3:0]       prev_opr_q;
    logic [3:0]       new_keys;
    move_state_e      mv_state_q, mv_state_d;
    dir_e             sel_q, sel_d;
    dir_e             move_dir_q, move_dir_d;
    logic             move_valid_q, move_valid_d;
    logic             mv_load, mv_zero, mv_cnt_en;
    logic [MV_W-1:0]  mv_load_val;
    logic             mv_press, sel_held;

    assign new_keys  = move_opr & ~prev_opr_q;
    assign mv_press  = enable && (new_keys != 4'b0000);
    assign sel_held  = move_opr[dir_key(sel_q)];
    assign mv_cnt_en = (mv_state_q == MV_HOLD);

    tick_down_counter #(.WIDTH(MV_W)) u_move_cnt (
        .clk_i      (clk_100Hz),
        .rst_ni     (rst_p),
        .load_i     (mv_load),
        .load_val_i (mv_load_val),
        .en_i       (mv_cnt_en),
        .zero_o     (mv_zero)
    );

    // Move state, selected key, edge register and registered outputs
    always_ff @(posedge clk_100Hz) begin
        if (!rst_p) begin
            prev_opr_q   <= '0;
            mv_state_q   <= MV_IDLE;
            sel_q        <= DIR_UP;
            move_valid_q <= 1'b0;
            move_dir_q   <= DIR_UP;
        end else begin
            prev_opr_q   <= move_opr;
            mv_state_q   <= mv_state_d;
            sel_q        <= sel_d;
            move_valid_q <= move_valid_d;
            move_dir_q   <= move_dir_d;
        end
    end

    // Move next state: disable forces IDLE, a new press always (re)enters HOLD
    always_comb begin
        mv_state_d = mv_state_q;
        if (!enable) begin
            mv_state_d = MV_IDLE;
        end else if (mv_press) begin
            mv_state_d = MV_HOLD;
        end else if ((mv_state_q == MV_HOLD) && !sel_held) begin
            mv_state_d = (move_opr != 4'b0000) ? MV_HOLD : MV_IDLE;
        end
    end

    // Move outputs: step strobes, key selection and counter reloads
    always_comb begin
        move_valid_d = 1'b0;
        move_dir_d   = move_dir_q;
        sel_d        = sel_q;
        mv_load      = 1'b0;
        mv_load_val  = '0;
        if (enable) begin
            if (mv_press) begin
                move_valid_d = 1'b1;
                move_dir_d   = prio_dir(new_keys);
                sel_d        = prio_dir(new_keys);
                mv_load      = 1'b1;
                mv_load_val  = MV_INIT_LD;
            end else if (mv_state_q == MV_HOLD) begin
                if (!sel_held) begin
                    // fall back to a still-held key without an immediate step
                    if (move_opr != 4'b0000) sel_d = prio_dir(move_opr);
                    mv_load     = 1'b1;
                    mv_load_val = MV_REP_LD;
                end else if (mv_zero) begin
                    move_valid_d = 1'b1;
                    move_dir_d   = sel_q;
                    mv_load      = 1'b1;
                    mv_load_val  = MV_REP_LD;
                end
            end
        end
    end

    assign move_valid = move_valid_q;
    assign move_dir   = move_dir_q;

    // ---------------- fire sequencer ----------------
    fire_state_e      fr_state_q, fr_state_d;
    logic [AMMO_W-1:0] rounds_q, rounds_d;
    logic [AMMO_W-1:0] ammo_q;
    logic             fire_q, fire_d;
    logic             reloading_q;
    logic             fr_load, fr_zero;
    logic [FR_W-1:0]  fr_load_val;
    logic             can_fire, last_round;

    assign can_fire   = enable && shoot_sign && (rounds_q != '0) && (fr_state_q == FR_READY);
    assign last_round = (rounds_q == AMMO_W'(1));

    tick_down_counter #(.WIDTH(FR_W)) u_fire_cnt (
        .clk_i      (clk_100Hz),
        .rst_ni     (rst_p),
        .load_i     (fr_load),
        .load_val_i (fr_load_val),
        .en_i       (enable),
        .zero_o     (fr_zero)
    );

    // Fire state, magazine and registered outputs; ammo/reloading show the
    // magazine one cycle after the shot so a refill is visible at the first
    // possible refire cycle
    always_ff @(posedge clk_100Hz) begin
        if (!rst_p) begin
            fr_state_q  <= FR_READY;
            rounds_q    <= AMMO_FULL;
            ammo_q      <= AMMO_FULL;
            fire_q      <= 1'b0;
            reloading_q <= 1'b0;
        end else begin
            fr_state_q  <= fr_state_d;
            rounds_q    <= rounds_d;
            ammo_q      <= rounds_q;
            fire_q      <= fire_d;
            reloading_q <= (fr_state_q == FR_RELOAD);
        end
    end

    // Fire next state: waits only progress while enabled
    always_comb begin
        fr_state_d = fr_state_q;
        case (fr_state_q)
            FR_READY:  if (can_fire) fr_state_d = last_round ? FR_RELOAD : FR_COOL;
            FR_COOL:   if (enable && fr_zero) fr_state_d = FR_READY;
            FR_RELOAD: if (enable && fr_zero) fr_state_d = FR_READY;
            default:   fr_state_d = FR_READY;
        endcase
    end

    // Fire outputs: shot strobe, magazine update and wait-counter loads
    always_comb begin
        fire_d      = 1'b0;
        rounds_d    = rounds_q;
        fr_load     = 1'b0;
        fr_load_val = '0;
        if (can_fire) begin
            fire_d      = 1'b1;
            rounds_d    = rounds_q - AMMO_W'(1);
            fr_load     = 1'b1;
            fr_load_val = last_round ? FR_RELOAD_LD : FR_COOL_LD;
        end else if ((fr_state_q == FR_RELOAD) && enable && fr_zero) begin
            rounds_d = AMMO_FULL;
        end
    end

    assign fire      = fire_q;
    assign ammo      = ammo_q;
    assign reloading = reloading_q;

endmodule

// File: tb/tb_player_action_ctrl.sv
// Bench for player_action_ctrl: directed scenarios plus randomized traffic
// checked against an event/deadline model of the move and fire rules.
module tb_player_action_ctrl;

    localparam int INIT_DLY     = 30;
    localparam int REPEAT       = 10;
    localparam int COOLDOWN     = 20;
    localparam int MAX_AMMO     = 6;
    localparam int RELOAD_TICKS = 150;

    logic       clk_100Hz = 1'b0;
    logic       rst_p, enable, shoot_sign;
    logic [3:0] move_opr;
    logic       move_valid, fire, reloading;
    logic [1:0] move_dir;
    logic [2:0] ammo;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_100Hz = ~clk_100Hz;

    player_action_ctrl #(
        .INIT_DLY     (INIT_DLY),
        .REPEAT       (REPEAT),
        .COOLDOWN     (COOLDOWN),
        .MAX_AMMO     (MAX_AMMO),
        .RELOAD_TICKS (RELOAD_TICKS)
    ) dut (
        .clk_100Hz  (clk_100Hz),
        .rst_p      (rst_p),
        .enable     (enable),
        .move_opr   (move_opr),
        .shoot_sign (shoot_sign),
        .move_valid (move_valid),
        .move_dir   (move_dir),
        .fire       (fire),
        .ammo       (ammo),
        .reloading  (reloading)
    );

    // ---------------- reference model (absolute-time deadlines) ----------------
    longint   t = 0;
    bit [3:0] m_prev;
    bit       m_active;
    int       m_key;
    longint   m_next;
    bit [1:0] m_dir;
    bit       m_busy, m_reload;
    longint   m_busy_end;
    int       m_rounds = MAX_AMMO;
    bit       exp_mv, exp_fire, exp_rel;
    bit [1:0] exp_dir;
    bit [2:0] exp_ammo;

    int       tcyc;
    int       mv_cyc[$];
    bit [1:0] mv_dirq[$];
    int       fire_cyc[$];

    function automatic int top_key(input bit [3:0] k);
        for (int b = 3; b >= 0; b--) if (k[b]) return b;
        return 0;
    endfunction

    task automatic model_step(input bit rst, input bit en, input bit [3:0] opr, input bit sh);
        bit [3:0] newk;
        if (!rst) begin
            m_prev = '0; m_active = 0; m_dir = 2'b00; m_busy = 0; m_reload = 0;
            m_rounds = MAX_AMMO;
            exp_mv = 0; exp_dir = 2'b00; exp_fire = 0; exp_ammo = 3'(MAX_AMMO); exp_rel = 0;
            t++;
            return;
        end
        newk   = opr & ~m_prev;
        exp_mv = 0;
        if (!en) begin
            m_active = 0;
        end else if (newk != 0) begin
            m_key = top_key(newk); m_active = 1; m_next = t + INIT_DLY;
            exp_mv = 1; m_dir = 2'(3 - m_key);
        end else if (m_active && !opr[m_key]) begin
            if (opr != 0) begin m_key = top_key(opr); m_next = t + REPEAT; end
            else m_active = 0;
        end else if (m_active && t == m_next) begin
            exp_mv = 1; m_dir = 2'(3 - m_key); m_next = t + REPEAT;
        end
        m_prev  = opr;
        exp_dir = m_dir;

        exp_rel  = m_busy && m_reload;
        exp_ammo = 3'(m_rounds);
        exp_fire = 0;
        if (m_busy) begin
            if (!en) m_busy_end++;
            else if (t == m_busy_end) begin
                m_busy = 0;
                if (m_reload) m_rounds = MAX_AMMO;
            end
        end else if (en && sh && m_rounds > 0) begin
            exp_fire = 1; m_rounds--; m_busy = 1;
            m_reload   = (m_rounds == 0);
            m_busy_end = m_reload ? t + RELOAD_TICKS : t + COOLDOWN - 1;
        end
        t++;
    endtask

    // One clock: drive inputs, step the model at the edge, sample #1 later
    task automatic tick(input bit rst, input bit en, input bit [3:0] opr, input bit sh);
        rst_p = rst; enable = en; move_opr = opr; shoot_sign = sh;
        @(posedge clk_100Hz);
        model_step(rst, en, opr, sh);
        #1;
        tcyc++;
        if (move_valid) begin mv_cyc.push_back(tcyc); mv_dirq.push_back(move_dir); end
        if (fire) fire_cyc.push_back(tcyc);
    endtask

    task automatic do_reset();
        tick(0, 1, 4'b0000, 0);
        tick(0, 1, 4'b0000, 0);
        mv_cyc.delete(); mv_dirq.delete(); fire_cyc.delete();
        tcyc = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_cmp++; if (move_valid !== 1'b0) begin n_bad++; $display("FAIL reset_move_valid: got %0b expected 0", move_valid); end
        n_cmp++; if (move_dir !== 2'b00) begin n_bad++; $display("FAIL reset_move_dir: got %0d expected 0", move_dir); end
        n_cmp++; if (fire !== 1'b0) begin n_bad++; $display("FAIL reset_fire: got %0b expected 0", fire); end
        n_cmp++; if (ammo !== 3'(MAX_AMMO)) begin n_bad++; $display("FAIL reset_ammo: got %0d expected %0d", ammo, MAX_AMMO); end
        n_cmp++; if (reloading !== 1'b0) begin n_bad++; $display("FAIL reset_reloading: got %0b expected 0", reloading); end
    endtask

    task automatic test_tap();
        do_reset();
        tick(1, 1, 4'b0010, 0);
        repeat (40) tick(1, 1, 4'b0000, 0);
        n_cmp++; if (mv_cyc.size() != 1) begin n_bad++; $display("FAIL tap_step_count: got %0d expected 1", mv_cyc.size()); end
        if (mv_cyc.size() >= 1) begin
            n_cmp++; if (mv_cyc[0] != 1) begin n_bad++; $display("FAIL tap_step_cycle: got %0d expected 1", mv_cyc[0]); end
            n_cmp++; if (mv_dirq[0] !== 2'b10) begin n_bad++; $display("FAIL tap_dir: got %0d expected 2", mv_dirq[0]); end
        end
    endtask

    task automatic test_hold_repeat();
        int exp_c[4] = '{1, 31, 41, 51};
        do_reset();
        repeat (60) tick(1, 1, 4'b1000, 0);
        repeat (5) tick(1, 1, 4'b0000, 0);
        n_cmp++; if (mv_cyc.size() != 4) begin n_bad++; $display("FAIL hold_step_count: got %0d expected 4", mv_cyc.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < mv_cyc.size()) begin
                n_cmp++;
                if (mv_cyc[i] != exp_c[i] || mv_dirq[i] !== 2'b00) begin
                    n_bad++;
                    $display("FAIL hold_step%0d: got cycle %0d dir %0d expected cycle %0d dir 0", i, mv_cyc[i], mv_dirq[i], exp_c[i]);
                end
            end
        end
    endtask

    task automatic test_preempt_release();
        int       exp_c[4] = '{1, 16, 36, 46};
        bit [1:0] exp_d[4] = '{2'b00, 2'b11, 2'b00, 2'b00};
        do_reset();
        for (int i = 0; i < 50; i++) tick(1, 1, (i >= 15 && i < 25) ? 4'b1001 : 4'b1000, 0);
        tick(1, 1, 4'b0000, 0);
        n_cmp++; if (mv_cyc.size() != 4) begin n_bad++; $display("FAIL preempt_step_count: got %0d expected 4", mv_cyc.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < mv_cyc.size()) begin
                n_cmp++;
                if (mv_cyc[i] != exp_c[i] || mv_dirq[i] !== exp_d[i]) begin
                    n_bad++;
                    $display("FAIL preempt_step%0d: got cycle %0d dir %0d expected cycle %0d dir %0d", i, mv_cyc[i], mv_dirq[i], exp_c[i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_simultaneous_press();
        do_reset();
        repeat (4) tick(1, 1, 4'b0101, 0);
        tick(1, 1, 4'b0000, 0);
        n_cmp++;
        if (mv_cyc.size() < 1 || mv_cyc[0] != 1 || mv_dirq[0] !== 2'b01) begin
            n_bad++;
            $display("FAIL simul_first_step: got %0d steps (cycle %0d dir %0d) expected cycle 1 dir 1",
                     mv_cyc.size(), (mv_cyc.size() > 0) ? mv_cyc[0] : -1, (mv_dirq.size() > 0) ? mv_dirq[0] : 2'b00);
        end
    endtask

    task automatic test_fire_reload();
        int exp_f[7] = '{1, 21, 41, 61, 81, 101, 252};
        int ammo_at[0:300];
        bit rel_at[0:300];
        int rel_n = 0;
        do_reset();
        for (int i = 0; i < 260; i++) begin
            tick(1, 1, 4'b0000, 1);
            ammo_at[tcyc] = int'(ammo); rel_at[tcyc] = reloading;
            if (reloading) rel_n++;
        end
        tick(1, 1, 4'b0000, 0);
        n_cmp++; if (fire_cyc.size() != 7) begin n_bad++; $display("FAIL fire_count: got %0d expected 7", fire_cyc.size()); end
        for (int i = 0; i < 7; i++) begin
            if (i < fire_cyc.size()) begin
                n_cmp++; if (fire_cyc[i] != exp_f[i]) begin n_bad++; $display("FAIL fire%0d_cycle: got %0d expected %0d", i, fire_cyc[i], exp_f[i]); end
            end
        end
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (ammo_at[exp_f[k] + 1] != 5 - k) begin n_bad++; $display("FAIL ammo_after_shot%0d: got %0d expected %0d", k, ammo_at[exp_f[k] + 1], 5 - k); end
        end
        n_cmp++; if (rel_at[101] !== 1'b0 || rel_at[102] !== 1'b1) begin n_bad++; $display("FAIL reload_start: got %0b%0b expected 01", rel_at[101], rel_at[102]); end
        n_cmp++; if (rel_at[251] !== 1'b1 || rel_at[252] !== 1'b0) begin n_bad++; $display("FAIL reload_end: got %0b%0b expected 10", rel_at[251], rel_at[252]); end
        n_cmp++; if (rel_n != RELOAD_TICKS) begin n_bad++; $display("FAIL reload_length: got %0d expected %0d", rel_n, RELOAD_TICKS); end
        n_cmp++; if (ammo_at[252] != MAX_AMMO || ammo_at[253] != MAX_AMMO - 1) begin n_bad++; $display("FAIL refill_ammo: got %0d,%0d expected 6,5", ammo_at[252], ammo_at[253]); end
    endtask

    task automatic test_freeze_and_reset();
        int ammo_at[0:300];
        bit rel_at[0:300];
        bit sh;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            sh = (i <= 100) || (i >= 262);
            tick(1, !(i >= 150 && i < 160), 4'b0000, sh);
            ammo_at[tcyc] = int'(ammo); rel_at[tcyc] = reloading;
        end
        n_cmp++; if (rel_at[252] !== 1'b1 || rel_at[261] !== 1'b1 || rel_at[262] !== 1'b0) begin
            n_bad++; $display("FAIL frozen_reload_end: got %0b%0b%0b expected 110", rel_at[252], rel_at[261], rel_at[262]); end
        n_cmp++; if (ammo_at[261] != 0 || ammo_at[262] != MAX_AMMO) begin
            n_bad++; $display("FAIL frozen_refill: got %0d,%0d expected 0,6", ammo_at[261], ammo_at[262]); end
        n_cmp++; if (ammo_at[300] != 4) begin n_bad++; $display("FAIL pre_reset_ammo: got %0d expected 4", ammo_at[300]); end
        tick(0, 1, 4'b1000, 1);
        n_cmp++; if ({move_valid, fire, reloading} !== 3'b000 || ammo !== 3'(MAX_AMMO)) begin
            n_bad++; $display("FAIL mid_run_reset: got mv=%0b fire=%0b rel=%0b ammo=%0d expected 0 0 0 6", move_valid, fire, reloading, ammo); end
        tick(1, 1, 4'b0000, 0);
        n_cmp++; if ({move_valid, fire, reloading} !== 3'b000 || ammo !== 3'(MAX_AMMO)) begin
            n_bad++; $display("FAIL after_reset_idle: got mv=%0b fire=%0b rel=%0b ammo=%0d expected 0 0 0 6", move_valid, fire, reloading, ammo); end
    endtask

    task automatic test_random();
        bit       r;
        bit       en = 1;
        bit       sh = 0;
        bit [3:0] opr = '0;
        int       k;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(599, 0) != 0);
            if (en && $urandom_range(59, 0) == 0) en = 0;
            else if (!en && $urandom_range(7, 0) == 0) en = 1;
            k = $urandom_range(39, 0);
            if (k == 0) opr = 4'($urandom);
            else if (k == 1) opr = '0;
            if ($urandom_range(9, 0) == 0) sh = ~sh;
            tick(r, en, opr, sh);
            n_cmp++;
            if ({move_valid, move_dir, fire, ammo, reloading} !== {exp_mv, exp_dir, exp_fire, exp_ammo, exp_rel}) begin
                n_bad++;
                $display("FAIL random@%0d: got mv=%0b dir=%0d fire=%0b ammo=%0d rel=%0b expected mv=%0b dir=%0d fire=%0b ammo=%0d rel=%0b",
                         i, move_valid, move_dir, fire, ammo, reloading, exp_mv, exp_dir, exp_fire, exp_ammo, exp_rel);
            end
        end
    endtask

    initial begin
        rst_p = 1'b0; enable = 1'b0; move_opr = '0; shoot_sign = 1'b0;
        test_reset();
        test_tap();
        test_hold_repeat();
        test_preempt_release();
        test_simultaneous_press();
        test_fire_reload();
        test_freeze_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
